// File: rtl/io_pkg.sv
// io_pkg: register map, status bit layout and shared RDY/OVR update rule for io_responder.
package io_pkg;
  localparam logic [15:0] IO_KDATA = 16'hF000;
  localparam logic [15:0] IO_KCTRL = 16'hF004;
  localparam logic [15:0] IO_SDATA = 16'hF010;
  localparam logic [15:0] IO_SCTRL = 16'hF014;
  localparam logic [15:0] IO_LEDR  = 16'hF800;
  localparam logic [15:0] IO_LEDG  = 16'hF804;
  localparam logic [15:0] IO_HEX   = 16'hF808;
  localparam logic [15:0] IO_TCNT  = 16'hFC00;
  localparam logic [15:0] IO_TLIM  = 16'hFC04;
  localparam logic [15:0] IO_TCTL  = 16'hFC08;
  localparam int RDY_BIT = 0;
  localparam int OVR_BIT = 2;
  localparam logic [15:0] IO_UNMAPPED = 16'hDEAD;
  localparam logic [3:0] KEY_RST = 4'hF;
  localparam logic [9:0] SW_RST = 10'h000;
  typedef struct packed {
    logic ovr;
    logic rdy;
  } status_t;
  // A write of 0 clears a flag; a same-cycle event still wins and sets RDY.
  function automatic status_t status_next(input status_t s, input logic wr,
                                          input logic w_rdy, input logic w_ovr,
                                          input logic ev);
    status_t n;
    n.rdy = ev | (s.rdy & ~(wr & ~w_rdy));
    n.ovr = (ev & s.rdy) | (s.ovr & ~(wr & ~w_ovr));
    return n;
  endfunction
  function automatic logic [15:0] status_word(input status_t s);
    logic [15:0] w;
    w = '0;
    w[RDY_BIT] = s.rdy;
    w[OVR_BIT] = s.ovr;
    return w;
  endfunction
endpackage

// File: rtl/io_responder_hex7seg.sv
// hex7seg: 4-bit value to active-low seven-segment pattern (gfedcba), digits 0-F.
module hex7seg (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped KEY/SW/LED/HEX/timer device registers on the processor data bus.
module io_responder
  import io_pkg::*;
#(
  parameter int DBITS = 16,
  parameter int TICK_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] din,
  input  logic             we,
  output logic [DBITS-1:0] dout,
  output logic             hit,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  logic [3:0] key_m, key_s, key_p;
  logic [9:0] sw_m, sw_s, sw_p;
  status_t kst, sst, tst;
  logic [DBITS-1:0] hex_r, tcnt, tlim;
  logic [PW-1:0] pre;
  logic wr_kctrl, wr_sctrl, wr_tctl, wr_tcnt, tick, t_wrap;
  assign wr_kctrl = we & (addr == IO_KCTRL);
  assign wr_sctrl = we & (addr == IO_SCTRL);
  assign wr_tctl  = we & (addr == IO_TCTL);
  assign wr_tcnt  = we & (addr == IO_TCNT);
  assign tick     = pre == PMAX;
  assign t_wrap   = (tlim != '0) && (tcnt == tlim - 1'b1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_m <= KEY_RST;
      key_s <= KEY_RST;
      key_p <= KEY_RST;
      sw_m  <= SW_RST;
      sw_s  <= SW_RST;
      sw_p  <= SW_RST;
      kst   <= '0;
      sst   <= '0;
      tst   <= '0;
      ledr  <= '0;
      ledg  <= '0;
      hex_r <= '0;
      tcnt  <= '0;
      tlim  <= '0;
      pre   <= '0;
    end else begin
      key_m <= key;
      key_s <= key_m;
      key_p <= key_s;
      sw_m  <= sw;
      sw_s  <= sw_m;
      sw_p  <= sw_s;
      kst   <= status_next(kst, wr_kctrl, din[RDY_BIT], din[OVR_BIT], key_s != key_p);
      sst   <= status_next(sst, wr_sctrl, din[RDY_BIT], din[OVR_BIT], sw_s != sw_p);
      // A TCNT write on a tick cycle suppresses the limit event.
      tst   <= status_next(tst, wr_tctl, din[RDY_BIT], din[OVR_BIT], tick & t_wrap & ~wr_tcnt);
      if (we && addr == IO_LEDR) ledr <= din[9:0];
      if (we && addr == IO_LEDG) ledg <= din[7:0];
      if (we && addr == IO_HEX) hex_r <= din;
      if (we && addr == IO_TLIM) tlim <= din;
      pre  <= (wr_tcnt || tick) ? '0 : pre + 1'b1;
      tcnt <= wr_tcnt ? din : tick ? (t_wrap ? '0 : tcnt + 1'b1) : tcnt;
    end
  end
  always_comb begin
    hit  = 1'b1;
    dout = '0;
    case (addr)
      IO_KDATA: dout = DBITS'(key_s);
      IO_KCTRL: dout = status_word(kst);
      IO_SDATA: dout = DBITS'(sw_s);
      IO_SCTRL: dout = status_word(sst);
      IO_LEDR:  dout = DBITS'(ledr);
      IO_LEDG:  dout = DBITS'(ledg);
      IO_HEX:   dout = hex_r;
      IO_TCNT:  dout = tcnt;
      IO_TLIM:  dout = tlim;
      IO_TCTL:  dout = status_word(tst);
      default: begin
        hit  = 1'b0;
        dout = IO_UNMAPPED;
      end
    endcase
  end
  hex7seg u_hex0 (.d(hex_r[3:0]),   .seg(hex0));
  hex7seg u_hex1 (.d(hex_r[7:4]),   .seg(hex1));
  hex7seg u_hex2 (.d(hex_r[11:8]),  .seg(hex2));
  hex7seg u_hex3 (.d(hex_r[15:12]), .seg(hex3));
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: randomized scoreboard bench for io_responder against a register-level reference model.
module tb_io_responder;
  localparam int T = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic we = 1'b0;
  logic [15:0] addr = 16'h0, din = 16'h0, dout;
  logic hit;
  logic [3:0] key = 4'hF;
  logic [9:0] sw = 10'h0, ledr;
  logic [7:0] ledg;
  logic [6:0] hex0, hex1, hex2, hex3;
  always #5 clk = ~clk;
  io_responder #(.DBITS(16), .TICK_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn), .addr(addr), .din(din), .we(we),
    .dout(dout), .hit(hit), .key(key), .sw(sw), .ledr(ledr), .ledg(ledg),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );
  typedef struct {
    int kind;
    logic [15:0] exp;
    logic [15:0] a;
  } chk_t;
  chk_t q[$];
  int passed = 0, total = 0, cyc = 0;
  logic done = 1'b0;
  logic rst_req = 1'b1;
  logic [3:0] key_v = 4'hF;
  logic [9:0] sw_v = 10'h0;
  logic [15:0] alist [12];
  logic [9:0] m_ledr;
  logic [7:0] m_ledg;
  logic [15:0] m_hex, m_tcnt, m_tlim;
  logic m_rdy [3];
  logic m_ovr [3];
  logic [3:0] kh [3];
  logic [9:0] sh [3];
  int m_since;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction
  function automatic string kname(input int k);
    case (k)
      0: return "dout"; 1: return "hit"; 2: return "ledr"; 3: return "ledg";
      4: return "hex0"; 5: return "hex1"; 6: return "hex2"; default: return "hex3";
    endcase
  endfunction
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h expected=%h t=%0t", n, got, exp, $time);
  endtask
  task automatic model_reset();
    m_ledr = '0; m_ledg = '0; m_hex = '0; m_tcnt = '0; m_tlim = '0; m_since = 0;
    for (int j = 0; j < 3; j++) begin
      m_rdy[j] = 1'b0; m_ovr[j] = 1'b0; kh[j] = 4'hF; sh[j] = 10'h0;
    end
  endtask
  task automatic model_edge();
    logic ev [3];
    logic tick, wr_t, wrap, w, old;
    logic [15:0] sa;
    ev[0] = kh[1] != kh[2];
    ev[1] = sh[1] != sh[2];
    tick = (m_since % T) == T - 1;
    wr_t = we && addr == 16'hFC00;
    wrap = m_tlim != 0 && m_tcnt == m_tlim - 16'd1;
    ev[2] = tick && wrap && !wr_t;
    for (int j = 0; j < 3; j++) begin
      sa = j == 0 ? 16'hF004 : j == 1 ? 16'hF014 : 16'hFC08;
      w = we && addr == sa;
      old = m_rdy[j];
      if (w && !din[0]) m_rdy[j] = 1'b0;
      if (w && !din[2]) m_ovr[j] = 1'b0;
      if (ev[j]) begin
        if (old) m_ovr[j] = 1'b1;
        m_rdy[j] = 1'b1;
      end
    end
    if (wr_t) begin
      m_tcnt = din;
      m_since = 0;
    end else begin
      if (tick) m_tcnt = wrap ? 16'd0 : m_tcnt + 16'd1;
      m_since++;
    end
    if (we && addr == 16'hF800) m_ledr = din[9:0];
    if (we && addr == 16'hF804) m_ledg = din[7:0];
    if (we && addr == 16'hF808) m_hex = din;
    if (we && addr == 16'hFC04) m_tlim = din;
    kh[2] = kh[1]; kh[1] = kh[0]; kh[0] = key;
    sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = sw;
  endtask
  function automatic logic [16:0] exp_read(input logic [15:0] a);
    case (a)
      16'hF000: return {1'b1, 12'h0, kh[1]};
      16'hF004: return {1'b1, 13'h0, m_ovr[0], 1'b0, m_rdy[0]};
      16'hF010: return {1'b1, 6'h0, sh[1]};
      16'hF014: return {1'b1, 13'h0, m_ovr[1], 1'b0, m_rdy[1]};
      16'hF800: return {1'b1, 6'h0, m_ledr};
      16'hF804: return {1'b1, 8'h0, m_ledg};
      16'hF808: return {1'b1, m_hex};
      16'hFC00: return {1'b1, m_tcnt};
      16'hFC04: return {1'b1, m_tlim};
      16'hFC08: return {1'b1, 13'h0, m_ovr[2], 1'b0, m_rdy[2]};
      default:  return {1'b0, 16'hDEAD};
    endcase
  endfunction
  task automatic push_outs();
    q.push_back('{2, {6'h0, m_ledr}, addr});
    q.push_back('{3, {8'h0, m_ledg}, addr});
    q.push_back('{4, {9'h0, seg7(m_hex[3:0])}, addr});
    q.push_back('{5, {9'h0, seg7(m_hex[7:4])}, addr});
    q.push_back('{6, {9'h0, seg7(m_hex[11:8])}, addr});
    q.push_back('{7, {9'h0, seg7(m_hex[15:12])}, addr});
  endtask
  task automatic step(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [16:0] r;
    @(posedge clk);
    if (resetn) model_edge();
    #1;
    resetn = !rst_req;
    if (rst_req) model_reset();
    we = w; addr = a; din = d; key = key_v; sw = sw_v;
    r = exp_read(a);
    q.push_back('{0, r[15:0], a});
    q.push_back('{1, {15'h0, r[16]}, a});
    cyc++;
    if (cyc % 4 == 0) push_outs();
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t c;
      logic [15:0] act;
      c = q.pop_front();
      case (c.kind)
        0: act = dout;
        1: act = {15'h0, hit};
        2: act = {6'h0, ledr};
        3: act = {8'h0, ledg};
        4: act = {9'h0, hex0};
        5: act = {9'h0, hex1};
        6: act = {9'h0, hex2};
        default: act = {9'h0, hex3};
      endcase
      total++;
      if (act === c.exp) passed++;
      else $display("FAIL %s addr=%h got=%h expected=%h t=%0t", kname(c.kind), c.a, act, c.exp, $time);
    end
  end
  initial begin
    #1000000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish t=%0t", $time);
      $finish;
    end
  end
  initial begin
    logic [15:0] a, d;
    alist[0] = 16'hF000; alist[1] = 16'hF004; alist[2] = 16'hF010; alist[3] = 16'hF014;
    alist[4] = 16'hF800; alist[5] = 16'hF804; alist[6] = 16'hF808; alist[7] = 16'hFC00;
    alist[8] = 16'hFC04; alist[9] = 16'hFC08; alist[10] = 16'h1234; alist[11] = 16'hF008;
    model_reset();
    rst_req = 1'b1;
    step(0, 16'h1234, 16'h0);
    step(0, 16'hFC00, 16'h0);
    @(negedge clk);
    chk("reset hex0", {9'h0, hex0}, 16'h0040);
    chk("reset hex1", {9'h0, hex1}, 16'h0040);
    chk("reset hex2", {9'h0, hex2}, 16'h0040);
    chk("reset hex3", {9'h0, hex3}, 16'h0040);
    chk("reset ledr", {6'h0, ledr}, 16'h0);
    chk("reset ledg", {8'h0, ledg}, 16'h0);
    chk("reset tcnt", dout, 16'h0);
    chk("reset hit", {15'h0, hit}, 16'h1);
    rst_req = 1'b0;
    step(1, 16'hF800, 16'h03FF);
    step(1, 16'hF804, 16'h00A5);
    step(1, 16'hF808, 16'h1F3C);
    step(0, 16'hF800, 16'h0);
    push_outs();
    step(0, 16'hF804, 16'h0);
    step(0, 16'hF808, 16'h0);
    key_v = 4'hE;
    for (int i = 0; i < 3; i++) step(0, 16'hF000, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 16'hF004, 16'h0);
    key_v = 4'hC;
    for (int i = 0; i < 5; i++) step(0, 16'hF004, 16'h0);
    step(1, 16'hF004, 16'h0);
    step(0, 16'hF004, 16'h0);
    sw_v = 10'h001;
    for (int i = 0; i < 5; i++) step(0, 16'hF014, 16'h0);
    sw_v = 10'h003;
    step(0, 16'hF014, 16'h0);
    step(0, 16'hF010, 16'h0);
    step(1, 16'hF014, 16'h0);
    step(0, 16'hF014, 16'h0);
    step(0, 16'hF014, 16'h0);
    step(1, 16'hFC04, 16'd3);
    step(1, 16'hFC00, 16'd0);
    for (int i = 0; i < 24; i++) step(0, (i % 2) ? 16'hFC08 : 16'hFC00, 16'h0);
    step(1, 16'hFC08, 16'h0);
    step(1, 16'hFC00, 16'd1);
    for (int i = 0; i < T - 1; i++) step(0, 16'hFC00, 16'h0);
    step(1, 16'hFC00, 16'd2);
    for (int i = 0; i < 6; i++) step(0, (i % 2) ? 16'hFC08 : 16'hFC00, 16'h0);
    step(1, 16'hFC04, 16'd0);
    step(1, 16'hFC08, 16'h0);
    step(1, 16'hFC00, 16'hFFFF);
    for (int i = 0; i < 10; i++) step(0, (i % 2) ? 16'hFC08 : 16'hFC00, 16'h0);
    rst_req = 1'b1;
    step(1, 16'hF800, 16'h0155);
    step(0, 16'h1234, 16'h0);
    rst_req = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) key_v = 4'($urandom);
      else if (r < 6) sw_v = 10'($urandom);
      rst_req = $urandom_range(0, 399) == 0;
      a = alist[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) begin
        d = 16'($urandom);
        if (a == 16'hFC04) d = 16'($urandom_range(0, 5));
        if (a == 16'hFC00) begin
          case ($urandom_range(0, 4))
            0: d = 16'd0; 1: d = 16'd1; 2: d = 16'd2; 3: d = 16'hFFFF; default: ;
          endcase
        end
        step(1, a, d);
      end else step(0, a, 16'h0);
    end
    rst_req = 1'b0;
    step(0, 16'h1234, 16'h0);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder sitting on the processor's data bus at the device address window (addresses with `addr[15:13]` nonzero), opposite the processor's MAR/`WrMem`/`DrMem` access path. It decodes processor loads and stores to device registers and drives the board I/O:
- inputs: KEY, SW;
- outputs: LEDR, LEDG, HEX0–HEX3;
- a millisecond interval timer.

Reads are combinational from the address, like the memory array; writes commit on the clock edge.

## Interface
- `DBITS`, 16: bus data/address width.
- `TICK_CYCLES`, 50000: clk cycles per timer tick (1 ms at 50 MHz); ≥2.
- `clk`  in  1: system clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `addr`  in  DBITS: byte address, from MAR.
- `din`  in  DBITS: write data, from the bus.
- `we`  in  1: store strobe, from `WrMem`.
- `dout`  out  DBITS: read data for the memout mux.
- `hit`  out  1: `addr` matches a defined register.
- `key`  in  4: raw KEY pins, active-low pressed.
- `sw`  in  10: raw SW pins.
- `ledr`  out  10, `ledg`  out  8: LED drivers.
- `hex0`..`hex3`  out  7 each: active-low seven-segment drivers.

## Operation
- Register map. Unmapped addresses: `hit`=0, `dout`=16'hDEAD, writes ignored.
  - 0xF000 KDATA, R: `{12'b0, key_s}`.
  - 0xF004 KCTRL, R/W: bit0 RDY, bit2 OVR.
  - 0xF010 SDATA, R: `{6'b0, sw_s}`.
  - 0xF014 SCTRL, R/W: bit0 RDY, bit2 OVR.
  - 0xF800 LEDR, R/W: low 10 bits.
  - 0xF804 LEDG, R/W: low 8 bits.
  - 0xF808 HEX, R/W: 16 bits; nibble *n* drives `hex`*n*.
  - 0xFC00 TCNT, R/W.
  - 0xFC04 TLIM, R/W.
  - 0xFC08 TCTL, R/W: bit0 RDY, bit2 OVR.
- `key`/`sw` pass through 2-flop synchronizers, giving `key_s`/`sw_s`. Change detection compares `key_s`/`sw_s` with the previous sampled value; any bit difference is an event.
- On an event: if RDY=1, set OVR; then set RDY.
- Status write (KCTRL/SCTRL/TCTL):
  - written 0 in bit0 clears RDY; 1 has no effect;
  - bit2 likewise: 0 clears OVR, 1 has no effect;
  - other bits are ignored and read as 0.
- Same-cycle status write and event: the event wins. RDY ends at 1; OVR is set only if RDY was 1 before the cycle.
- Timer:
  - prescaler counts 0..TICK_CYCLES-1 and produces a tick on wrap;
  - each tick: if TLIM≠0 and TCNT==TLIM-1, then TCNT←0 and the RDY/OVR event rule applies; otherwise TCNT←TCNT+1, wrapping modulo 2^16;
  - TLIM=0 means TCNT free-runs with no events.
- Writing TCNT loads `din` and clears the prescaler. If this coincides with a tick, the write wins and no event occurs.
- Writing TLIM does not touch TCNT.
- Reads never have side effects.

## Timing
- `dout`/`hit` are combinational from `addr` and current register state; there are no read wait states.
- Writes take effect at the posedge where `we`=1 and the address is mapped. A readback is visible in the next cycle.
- A pin change reaches KDATA/SDATA 2 clk cycles later. RDY sets 3 cycles after the pin change, i.e. one cycle after the data register shows it.
- First timer tick: TICK_CYCLES cycles after reset release or after a TCNT write.
- Reset (asynchronous, any time, including mid-write):
  - all R/W registers, RDY/OVR, prescaler and TCNT go to 0; TLIM goes to 0;
  - synchronizers and previous-value flops go to all-1 for KEY (released) and 0 for SW;
  - `ledr`/`ledg` = 0;
  - `hex`*n* = 7'b1000000 (digit 0).
- Outputs `ledr`, `ledg`, `hex`* are registered/decoded from registers only, so they have no combinational path from `din`.

## Structure
- Shared package `io_pkg`:
  - register address constants (`IO_KDATA` … `IO_TCTL`);
  - status bit positions (`RDY_BIT`=0, `OVR_BIT`=2);
  - unmapped read value 16'hDEAD;
  - KEY/SW reset values.
- One natural sub-module, `hex7seg`: 4-bit to active-low 7-segment decoder for 0–F, instantiated 4×.
- Status logic (RDY/OVR) is shared as one function or task, used three times.

## Test plan
- Reset: assert `resetn`=0 mid-stream. Expect all readbacks 0, `hex0..3`=7'b1000000, `dout` at 0x1234 = 16'hDEAD, `hit`=0.
- LED/HEX: write 0x03FF to LEDR, 0x00A5 to LEDG, 0x1F3C to HEX.
  - `ledr`=10'h3FF, `ledg`=8'hA5.
  - `hex3`=1, `hex2`=F, `hex1`=3, `hex0`=C patterns (7'b1111001, 7'b0001110, 7'b0110000, 7'b1000110).
  - Readbacks match.
- KEY events:
  - drop `key[0]` to 0. KDATA=0xE after 2 cycles; KCTRL=0x1 one cycle later.
  - change `key[1]` without clearing: KCTRL=0x5.
  - write 0 to KCTRL: reads 0x0.
- Simultaneous: status clear in the same cycle as an SW change with RDY=1. Expect SCTRL=0x5 afterwards.
- Timer with TICK_CYCLES=4: write TLIM=3, TCNT=0.
  - TCNT sequence 1,2,0 at 4-cycle spacing; TCTL=0x1 at the wrap, then 0x5 at the next wrap if not cleared.
  - TCNT write on a tick cycle: loaded value holds, no event.
- Free-run: TLIM=0, TCNT=0xFFFF. Next tick gives TCNT=0 and TCTL stays 0.
